// File: rtl/misr_pkg.sv
// misr_pkg: shared definitions for the MISR signature compactor.
//   state_t        FSM encoding (IDLE / COMPACT / DONE)
//   DEF_T1..DEF_T4 default feedback taps, identical to the pattern LFSR's
package misr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPACT = 2'b01,
        DONE    = 2'b10
    } state_t;

    localparam int DEF_T1 = 1;
    localparam int DEF_T2 = 5;
    localparam int DEF_T3 = 6;
    localparam int DEF_T4 = 31;

endpackage

// File: rtl/misr_core.sv
// misr_core: signature register S with tap feedback.
//   clk, reset  clock, asynchronous active-low reset
//   clr         synchronous clear of S (wins over en)
//   en          absorb din: S <= {S[N-2:0], fb} ^ din
//   din         response word
//   sig         current signature S
module misr_core
    import misr_pkg::*;
#(
    parameter int MISR_MSG_BITS = 32,
    parameter int T1 = DEF_T1,
    parameter int T2 = DEF_T2,
    parameter int T3 = DEF_T3,
    parameter int T4 = DEF_T4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic [MISR_MSG_BITS-1:0] din,
    output logic [MISR_MSG_BITS-1:0] sig
);

    logic fb;

    assign fb = sig[T1] ^ sig[T2] ^ sig[T3] ^ sig[T4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sig <= '0;
        else if (clr)
            sig <= '0;
        else if (en)
            sig <= {sig[MISR_MSG_BITS-2:0], fb} ^ din;
    end

endmodule

// File: rtl/misr.sv
// misr: multiple-input signature register for BIST response compaction.
// A start request loads the response count; that many CUT words are then
// folded into S, and the final signature is offered until accepted.
//   clk, reset                 clock, asynchronous active-low reset
//   req_val/req_rdy/req_msg    start request, req_msg = response count
//   cut_val/cut_rdy/cut_msg    CUT response words
//   resp_val/resp_rdy/resp_msg final signature
// Optional macro MISR_SIG_CHECK_EN adds:
//   exp_sig  expected signature, captured on the request handshake
//   pass     (S == exp_sig) while in DONE, else 0
module misr
    import misr_pkg::*;
#(
    parameter int MISR_MSG_BITS = 32,
    parameter int T1 = DEF_T1,
    parameter int T2 = DEF_T2,
    parameter int T3 = DEF_T3,
    parameter int T4 = DEF_T4,
    parameter int CNT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic [CNT_BITS-1:0]      req_msg,
    input  logic                     cut_val,
    output logic                     cut_rdy,
    input  logic [MISR_MSG_BITS-1:0] cut_msg,
`ifdef MISR_SIG_CHECK_EN
    input  logic [MISR_MSG_BITS-1:0] exp_sig,
    output logic                     pass,
`endif
    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic [MISR_MSG_BITS-1:0] resp_msg
);

    state_t                   state;
    logic [CNT_BITS-1:0]      cnt;
    logic [MISR_MSG_BITS-1:0] sig;
    logic                     clr;
    logic                     beat;

    assign clr  = (state == IDLE) && req_val;
    assign beat = (state == COMPACT) && cut_val;

    misr_core #(
        .MISR_MSG_BITS(MISR_MSG_BITS),
        .T1(T1), .T2(T2), .T3(T3), .T4(T4)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .en   (beat),
        .din  (cut_msg),
        .sig  (sig)
    );

    // A zero count goes straight to DONE, so COMPACT never holds cnt==0
    // and the decrement cannot wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (req_val) begin
                    cnt   <= req_msg;
                    state <= (req_msg == '0) ? DONE : COMPACT;
                end
                COMPACT: if (cut_val) begin
                    cnt <= cnt - CNT_BITS'(1);
                    if (cnt == CNT_BITS'(1))
                        state <= DONE;
                end
                DONE: if (resp_rdy)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the state register only, so they follow reset at once.
    assign req_rdy  = (state == IDLE);
    assign cut_rdy  = (state == COMPACT);
    assign resp_val = (state == DONE);
    assign resp_msg = (state == DONE) ? sig : '0;

`ifdef MISR_SIG_CHECK_EN
    logic [MISR_MSG_BITS-1:0] exp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            exp_q <= '0;
        else if (clr)
            exp_q <= exp_sig;
    end

    assign pass = (state == DONE) && (sig == exp_q);
`endif

endmodule
